// File: rtl/btn_counter_src_if.sv
// Button/switch inputs and display-facing outputs of the button counter source.
interface btn_counter_src_if;
  logic        btn_inc;
  logic        btn_dec;
  logic        btn_load;
  logic [15:0] sw;
  logic [31:0] data;
  logic [15:0] cdata;
  logic [2:0]  press;

  // The counter source receives the raw buttons/switches and drives the display outputs.
  modport master (
    input  btn_inc, btn_dec, btn_load, sw,
    output data, cdata, press
  );

  // The stimulus/display side drives the raw inputs and consumes the outputs.
  modport slave (
    output btn_inc, btn_dec, btn_load, sw,
    input  data, cdata, press
  );
endinterface

// File: rtl/btn_counter_src.sv
// Button-driven data source for the hex display: synchronises and debounces three
// push-buttons, keeps a 16-bit up/down value and a saturating press counter, and
// presents {switches, value} plus the press count to the display.
module btn_counter_src #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DB_W            = 16
) (
  input  logic              clk,
  input  logic              rst,
  btn_counter_src_if.master bus
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Button bit order everywhere is {load, dec, inc}.
  logic [2:0]      btn_raw;
  logic [2:0]      btn_s1;
  logic [2:0]      btn_s2;
  logic [2:0]      stable;
  logic [2:0]      stable_d;
  logic [2:0]      press;
  logic [DB_W-1:0] db_cnt [3];
  logic [15:0]     sw_s1;
  logic [15:0]     sw_q;
  logic [15:0]     value;
  logic [15:0]     press_cnt;

  assign btn_raw = {bus.btn_load, bus.btn_dec, bus.btn_inc};

  // Two-flop synchronisers for the asynchronous buttons and switches.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_q   <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      sw_s1  <= bus.sw;
      sw_q   <= sw_s1;
    end
  end

  // Per-button debounce: the stable level follows the synced input only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      for (int k = 0; k < 3; k++) db_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (btn_s2[k] == stable[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          stable[k] <= btn_s2[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // Delayed copy of the stable levels for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) stable_d <= '0;
    else     stable_d <= stable;
  end

  assign press = stable & ~stable_d;

  // Value update on a press cycle; load wins, inc+dec together cancel, inc/dec wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (press[2]) begin
      value <= sw_q;
    end else if (press[1] && press[0]) begin
      value <= value;
    end else if (press[0]) begin
      value <= value + 16'd1;
    end else if (press[1]) begin
      value <= value - 16'd1;
    end
  end

  // Press counter: one count per cycle with any pulse, holding at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_cnt <= '0;
    end else if ((|press) && (press_cnt != 16'hFFFF)) begin
      press_cnt <= press_cnt + 16'd1;
    end
  end

  assign bus.data  = {sw_q, value};
  assign bus.cdata = press_cnt;
  assign bus.press = press;

endmodule

// File: tb/tb_btn_counter_src.sv
// Self-checking bench for btn_counter_src with a short debounce window.
module tb_btn_counter_src;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  btn_counter_src_if bus ();

  btn_counter_src #(.DEBOUNCE_CYCLES(D), .DB_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: raw sample history, debounced levels from "last D synced samples
  // all disagree with the current level", and plain arithmetic for value/count.
  bit [2:0]  hist[$];
  bit [15:0] swh[$];
  bit [2:0]  m_stable, m_stable_d;
  bit [15:0] m_value, m_cnt;
  bit [15:0] cur_sw;
  bit [2:0]  seen_press;

  task automatic model_edge(bit r, bit [2:0] raw, bit [15:0] swraw);
    if (r) begin
      hist = {};
      repeat (D + 2) hist.push_back(3'b000);
      swh = {};
      repeat (2) swh.push_back(16'h0000);
      m_stable   = '0;
      m_stable_d = '0;
      m_value    = '0;
      m_cnt      = '0;
    end else begin
      bit [2:0] pr  = m_stable & ~m_stable_d;
      bit [2:0] nst = m_stable;
      if (pr[2])                 m_value = swh[0];
      else if (pr[1] && pr[0])   m_value = m_value;
      else if (pr[0])            m_value = m_value + 16'd1;
      else if (pr[1])            m_value = m_value - 16'd1;
      if (pr != 3'b000 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      for (int k = 0; k < 3; k++) begin
        bit all_diff = 1'b1;
        for (int i = 0; i < D; i++)
          if (hist[hist.size() - 2 - i][k] == m_stable[k]) all_diff = 1'b0;
        if (all_diff) nst[k] = ~m_stable[k];
      end
      m_stable_d = m_stable;
      m_stable   = nst;
      hist.push_back(raw);
      void'(hist.pop_front());
      swh.push_back(swraw);
      void'(swh.pop_front());
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance model on the edge, compare just after the edge.
  task automatic step(bit r, bit [2:0] b, bit [15:0] s);
    rst          = r;
    bus.btn_inc  = b[0];
    bus.btn_dec  = b[1];
    bus.btn_load = b[2];
    bus.sw       = s;
    @(posedge clk);
    model_edge(r, b, s);
    #1;
    seen_press = seen_press | bus.press;
    chk("data",  bus.data,           {swh[0], m_value});
    chk("cdata", {16'h0, bus.cdata}, {16'h0, m_cnt});
    chk("press", {29'h0, bus.press}, {29'h0, m_stable & ~m_stable_d});
  endtask

  task automatic press_btn(bit [2:0] b);
    repeat (D + 6) step(1'b0, b, cur_sw);
    repeat (D + 6) step(1'b0, 3'b000, cur_sw);
  endtask

  initial begin
    cur_sw     = 16'h0000;
    seen_press = '0;

    // Reset, then a held inc press: pulse after edge D+2, value 1 after edge D+3.
    repeat (3) step(1'b1, 3'b000, cur_sw);
    chk("rst_data",  bus.data,           32'h0);
    chk("rst_cdata", {16'h0, bus.cdata}, 32'h0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 3'b001, cur_sw);
      if (i == D + 2) begin
        chk("inc_press_e6", {29'h0, bus.press}, 32'h1);
        chk("inc_value_e6", {16'h0, bus.data[15:0]}, 32'h0);
      end
      if (i == D + 3) chk("inc_value_e7", {16'h0, bus.data[15:0]}, 32'h1);
    end
    seen_press = '0;
    repeat (15) step(1'b0, 3'b000, cur_sw);
    chk("release_no_pulse", {29'h0, seen_press}, 32'h0);
    chk("inc_cdata", {16'h0, bus.cdata}, 32'h1);

    // Short dec glitch must be ignored.
    repeat (D - 1) step(1'b0, 3'b010, cur_sw);
    repeat (12) step(1'b0, 3'b000, cur_sw);
    chk("glitch_press", {29'h0, seen_press}, 32'h0);
    chk("glitch_value", {16'h0, bus.data[15:0]}, 32'h1);

    // Wrap both ways.
    press_btn(3'b010);
    chk("dec_to_0", {16'h0, bus.data[15:0]}, 32'h0);
    press_btn(3'b010);
    chk("dec_wrap", {16'h0, bus.data[15:0]}, 32'hFFFF);
    press_btn(3'b001);
    chk("inc_wrap", {16'h0, bus.data[15:0]}, 32'h0);
    chk("wrap_cdata", {16'h0, bus.cdata}, 32'h4);

    // Switch pass-through latency and load.
    cur_sw = 16'hA5C3;
    step(1'b0, 3'b000, cur_sw);
    step(1'b0, 3'b000, cur_sw);
    chk("sw_2cyc", {16'h0, bus.data[31:16]}, 32'hA5C3);
    press_btn(3'b100);
    chk("load_value", {16'h0, bus.data[15:0]}, 32'hA5C3);

    // inc and dec together: both pulse, value unchanged, one count.
    seen_press = '0;
    press_btn(3'b011);
    chk("both_press", {29'h0, seen_press}, 32'h3);
    chk("both_value", {16'h0, bus.data[15:0]}, 32'hA5C3);
    chk("both_cdata", {16'h0, bus.cdata}, 32'h6);

    // Saturation of the press counter.
    force dut.press_cnt = 16'hFFFE;
    #1;
    release dut.press_cnt;
    m_cnt = 16'hFFFE;
    repeat (3) press_btn(3'b001);
    chk("sat_cdata", {16'h0, bus.cdata}, 32'hFFFF);
    chk("sat_value", {16'h0, bus.data[15:0]}, 32'hA5C6);

    // Reset mid-debounce, button held through reset release.
    repeat (4) step(1'b0, 3'b001, cur_sw);
    repeat (2) step(1'b1, 3'b001, cur_sw);
    chk("mid_rst_data",  bus.data,           32'h0);
    chk("mid_rst_cdata", {16'h0, bus.cdata}, 32'h0);
    chk("mid_rst_press", {29'h0, bus.press}, 32'h0);
    repeat (D + 6) step(1'b0, 3'b001, cur_sw);
    chk("held_thru_rst", {16'h0, bus.data[15:0]}, 32'h1);
    repeat (D + 6) step(1'b0, 3'b000, cur_sw);

    // Random button runs, switches and occasional resets against the model.
    for (int n = 0; n < 80; n++) begin
      automatic bit [2:0]  b   = 3'($urandom_range(0, 7));
      automatic int        len = $urandom_range(1, 9);
      automatic bit        r   = ($urandom_range(0, 24) == 0);
      cur_sw = 16'($urandom);
      for (int j = 0; j < len; j++) step(r && (j == 0), b, cur_sw);
    end
    repeat (D + 4) step(1'b0, 3'b000, cur_sw);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
